// File: rtl/tree_mac_pkg.sv
// tree_mac_pkg: shared types and sizing helpers for the tree MAC slice.
// Holds the accumulator state enum, reference geometry and width helpers.
package tree_mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  function automatic int tree_levels(input int len);
    return (len > 1) ? $clog2(len) : 0;
  endfunction

  function automatic int pad_len(input int len);
    return 1 << tree_levels(len);
  endfunction

  // Each registered tree level widens the partial sums by one bit.
  function automatic int sum_width(input int in_w, input int level);
    return in_w + level;
  endfunction

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DATA_LENGTH = 64;
  localparam int PAD_LEN         = pad_len(DEF_DATA_LENGTH);
  localparam int TREE_LEVELS     = tree_levels(DEF_DATA_LENGTH);
  localparam int PROD_WIDTH      = 2 * DEF_DATA_WIDTH;

endpackage

// File: rtl/tree_mac_adder_tree.sv
// tree_mac_adder_tree: registered binary reduction of LEN products.
// Ports: clk; in_i = LEN x IN_WIDTH packed terms; sum_o = full-width sum.
// Leaves above LEN are zero; one register per level, no reset.
module tree_mac_adder_tree
  import tree_mac_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int LEN         = 64,
  parameter int SIGNED_MODE = 0,
  localparam int LEVELS     = tree_levels(LEN),
  localparam int OUT_WIDTH  = sum_width(IN_WIDTH, LEVELS)
) (
  input  logic                    clk,
  input  logic [IN_WIDTH*LEN-1:0] in_i,
  output logic [OUT_WIDTH-1:0]    sum_o
);

  localparam int PAD = pad_len(LEN);
  localparam bit SX  = (SIGNED_MODE != 0);

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = sum_width(IN_WIDTH, l);
    for (genvar j = 0; j < (PAD >> l); j++) begin : g_n
      logic [W-1:0] q;
      if (l == 0) begin : g_leaf
        if (j < LEN) begin : g_op
          assign q = in_i[j*IN_WIDTH +: IN_WIDTH];
        end else begin : g_pad
          assign q = '0;
        end
      end else begin : g_add
        logic [W-2:0] a;
        logic [W-2:0] b;
        assign a = g_lvl[l-1].g_n[2*j].q;
        assign b = g_lvl[l-1].g_n[2*j+1].q;
        always_ff @(posedge clk) begin
          q <= {SX & a[W-2], a} + {SX & b[W-2], b};
        end
      end
    end
  end

  assign sum_o = g_lvl[LEVELS].g_n[0].q;

endmodule

// File: rtl/tree_mac_accum.sv
// tree_mac_accum: pipelined dot product folded into K-tiled accumulations.
// In: clk, reset (async low), row/col vectors, val_in, last_in, addr_i/k_in.
// Out: sum_out, val_out pulse, addr_i/k_out, beat_cnt, sat_out.
// Macro TREE_MAC_SAT_EN: saturating accumulate and live sat_out.
module tree_mac_accum
  import tree_mac_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_LENGTH     = 64,
  parameter int ACC_WIDTH       = 32,
  parameter int SIGNED_MODE     = 0,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] row,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] col,
  input  logic                              val_in,
  input  logic                              last_in,
  input  logic [ADDRESS_WIDTH_I-1:0]        addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]        addr_k_in,
  output logic [ACC_WIDTH-1:0]              sum_out,
  output logic                              val_out,
  output logic [ADDRESS_WIDTH_I-1:0]        addr_i_out,
  output logic [ADDRESS_WIDTH_K-1:0]        addr_k_out,
  output logic [CNT_WIDTH-1:0]              beat_cnt,
  output logic                              sat_out
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int L  = tree_levels(DATA_LENGTH);
  localparam int TW = sum_width(PW, L);
  localparam int D  = 2 + L;
  localparam int VW = DW * DATA_LENGTH;
  localparam int AW = ACC_WIDTH;
  localparam bit SX = (SIGNED_MODE != 0);

  logic [VW-1:0]             row_q;
  logic [VW-1:0]             col_q;
  logic [PW*DATA_LENGTH-1:0] prod_d;
  logic [PW*DATA_LENGTH-1:0] prod_q;
  logic [TW-1:0]             tree_o;
  logic [AW-1:0]             beat;

  always_ff @(posedge clk) begin
    row_q  <= row;
    col_q  <= col;
    prod_q <= prod_d;
  end

  // Extending to full product width first makes the low PW bits
  // of the product correct for either operand mode.
  for (genvar e = 0; e < DATA_LENGTH; e++) begin : g_mul
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    assign a  = row_q[e*DW +: DW];
    assign b  = col_q[e*DW +: DW];
    assign ax = {{DW{SX & a[DW-1]}}, a};
    assign bx = {{DW{SX & b[DW-1]}}, b};
    assign prod_d[e*PW +: PW] = ax * bx;
  end

  tree_mac_adder_tree #(
    .IN_WIDTH   (PW),
    .LEN        (DATA_LENGTH),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_tree (
    .clk  (clk),
    .in_i (prod_q),
    .sum_o(tree_o)
  );

  if (AW > TW) begin : g_ext
    assign beat = {{(AW-TW){SX & tree_o[TW-1]}}, tree_o};
  end else begin : g_fit
    assign beat = tree_o[AW-1:0];
  end

  // Control chain: matches operand + multiply + tree depth.
  logic [D-1:0]               vld_q;
  logic [D-1:0]               last_q;
  logic [ADDRESS_WIDTH_I-1:0] ai_q [D];
  logic [ADDRESS_WIDTH_K-1:0] ak_q [D];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= {vld_q[D-2:0], val_in};
  end

  always_ff @(posedge clk) begin
    last_q  <= {last_q[D-2:0], last_in};
    ai_q[0] <= addr_i_in;
    ak_q[0] <= addr_k_in;
    for (int s = 1; s < D; s++) begin
      ai_q[s] <= ai_q[s-1];
      ak_q[s] <= ak_q[s-1];
    end
  end

  logic a_vld;
  logic a_last;
  assign a_vld  = vld_q[D-1];
  assign a_last = last_q[D-1];

  acc_state_e           state_q;
  logic [AW-1:0]        acc_q;
  logic [AW-1:0]        sum_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef TREE_MAC_SAT_EN
  logic [AW:0]   sum_x;
  logic          ovf;
  logic [AW-1:0] clamp;
  logic          sat_q;
  logic          sat_d;
  logic          sat_o_q;

  assign sum_x = {SX & acc_q[AW-1], acc_q} + {SX & beat[AW-1], beat};
  assign ovf   = SX ? (sum_x[AW] ^ sum_x[AW-1]) : sum_x[AW];
  assign clamp = !SX ? '1 :
                 sum_x[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  // Once clamped, the group keeps the clamp value until it ends.
  assign sum_d = sat_q ? acc_q : (ovf ? clamp : sum_x[AW-1:0]);
  assign sat_d = sat_q | ovf;
  assign sat_out = sat_o_q;
`else
  assign sum_d   = acc_q + beat;
  assign sat_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      val_out    <= 1'b0;
      sum_out    <= '0;
      addr_i_out <= '0;
      addr_k_out <= '0;
      beat_cnt   <= '0;
`ifdef TREE_MAC_SAT_EN
      sat_q      <= 1'b0;
      sat_o_q    <= 1'b0;
`endif
    end else begin
      val_out <= 1'b0;
      if (a_vld) begin
        unique case (state_q)
          IDLE: begin
`ifdef TREE_MAC_SAT_EN
            sat_q <= 1'b0;
`endif
            if (a_last) begin
              val_out    <= 1'b1;
              sum_out    <= beat;
              beat_cnt   <= CNT_WIDTH'(1);
              addr_i_out <= ai_q[D-1];
              addr_k_out <= ak_q[D-1];
`ifdef TREE_MAC_SAT_EN
              sat_o_q    <= 1'b0;
`endif
            end else begin
              acc_q   <= beat;
              cnt_q   <= CNT_WIDTH'(1);
              state_q <= ACCUM;
            end
          end
          ACCUM: begin
`ifdef TREE_MAC_SAT_EN
            sat_q <= sat_d;
`endif
            if (a_last) begin
              val_out    <= 1'b1;
              sum_out    <= sum_d;
              beat_cnt   <= cnt_d;
              addr_i_out <= ai_q[D-1];
              addr_k_out <= ak_q[D-1];
              state_q    <= IDLE;
`ifdef TREE_MAC_SAT_EN
              sat_o_q    <= sat_d;
`endif
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tree_mac_accum.sv
// tb_tree_mac_accum: scoreboard bench for three tree_mac_accum builds.
// DL=4 DW=8: unsigned/32, signed/32, unsigned/18 sharing one stimulus.
module tb_tree_mac_accum;

  localparam int LAT = 5;

  logic        clk;
  logic        rst_n;
  logic [31:0] row;
  logic [31:0] col;
  logic        val;
  logic        last;
  logic [7:0]  ai_in;
  logic [7:0]  ak_in;

  logic        v0, v1, v2;
  logic [31:0] s0, s1;
  logic [17:0] s2;
  logic [7:0]  ai0, ai1, ai2, ak0, ak1, ak2, c0, c1, c2;
  logic        t0, t1, t2;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  typedef struct {
    longint     sum;
    logic [7:0] ai;
    logic [7:0] ak;
    logic [7:0] cnt;
    bit         sat;
    longint     cyc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  longint m_acc [3];
  int     m_cnt [3];
  bit     m_sat [3];
  bit     m_busy;

  tree_mac_accum #(
    .DATA_WIDTH(8), .DATA_LENGTH(4), .ACC_WIDTH(32), .SIGNED_MODE(0),
    .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .val_in(val),
    .last_in(last), .addr_i_in(ai_in), .addr_k_in(ak_in),
    .sum_out(s0), .val_out(v0), .addr_i_out(ai0), .addr_k_out(ak0),
    .beat_cnt(c0), .sat_out(t0)
  );

  tree_mac_accum #(
    .DATA_WIDTH(8), .DATA_LENGTH(4), .ACC_WIDTH(32), .SIGNED_MODE(1),
    .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .CNT_WIDTH(8)
  ) u_sgn (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .val_in(val),
    .last_in(last), .addr_i_in(ai_in), .addr_k_in(ak_in),
    .sum_out(s1), .val_out(v1), .addr_i_out(ai1), .addr_k_out(ak1),
    .beat_cnt(c1), .sat_out(t1)
  );

  tree_mac_accum #(
    .DATA_WIDTH(8), .DATA_LENGTH(4), .ACC_WIDTH(18), .SIGNED_MODE(0),
    .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .CNT_WIDTH(8)
  ) u_nar (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .val_in(val),
    .last_in(last), .addr_i_in(ai_in), .addr_k_in(ak_in),
    .sum_out(s2), .val_out(v2), .addr_i_out(ai2), .addr_k_out(ak2),
    .beat_cnt(c2), .sat_out(t2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cw(input int id);
    return (id == 2) ? 18 : 32;
  endfunction

  function automatic bit cs(input int id);
    return id == 1;
  endfunction

  function automatic longint dotp(input logic [31:0] r,
                                  input logic [31:0] c, input bit sg);
    longint s;
    longint a;
    longint b;
    s = 0;
    for (int e = 0; e < 4; e++) begin
      a = sg ? longint'($signed(r[e*8 +: 8])) : longint'(r[e*8 +: 8]);
      b = sg ? longint'($signed(c[e*8 +: 8])) : longint'(c[e*8 +: 8]);
      s += a * b;
    end
    return s;
  endfunction

  function automatic longint fold(input longint acc, input longint b,
                                 input int id, inout bit sat);
    longint s;
    longint m;
    longint mx;
    if (sat) return acc;
    s  = acc + b;
    m  = longint'(1) << cw(id);
    mx = cs(id) ? m / 2 - 1 : m - 1;
`ifdef TREE_MAC_SAT_EN
    begin
      longint mn;
      mn = cs(id) ? -(m / 2) : 0;
      if (s > mx) begin sat = 1'b1; return mx; end
      if (s < mn) begin sat = 1'b1; return mn; end
      return s;
    end
`else
    s = s % m;
    if (s < 0) s += m;
    if (s > mx) s -= m;
    return s;
`endif
  endfunction

  task automatic model_beat(input logic [31:0] r, input logic [31:0] c,
                            input bit l, input logic [7:0] ai,
                            input logic [7:0] ak);
    for (int id = 0; id < 3; id++) begin
      longint b;
      bit     t;
      exp_t   e;
      b = dotp(r, c, cs(id));
      if (!m_busy) begin
        m_acc[id] = b;
        m_cnt[id] = 1;
        m_sat[id] = 1'b0;
      end else begin
        t = m_sat[id];
        m_acc[id] = fold(m_acc[id], b, id, t);
        m_sat[id] = t;
        m_cnt[id] = (m_cnt[id] < 255) ? m_cnt[id] + 1 : 255;
      end
      if (l) begin
        e.sum = m_acc[id];
        e.ai  = ai;
        e.ak  = ak;
        e.cnt = 8'(m_cnt[id]);
        e.sat = m_sat[id];
        e.cyc = cyc;
        if (id == 0) q0.push_back(e);
        else if (id == 1) q1.push_back(e);
        else q2.push_back(e);
      end
    end
    m_busy = !l;
  endtask

  task automatic drive(input logic [31:0] r, input logic [31:0] c,
                       input bit v, input bit l,
                       input logic [7:0] ai, input logic [7:0] ak);
    @(negedge clk);
    row = r; col = c; val = v; last = l; ai_in = ai; ak_in = ak;
    if (v) model_beat(r, c, l, ai, ak);
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic take(input int id, input logic [63:0] sum,
                      input logic [7:0] ai, input logic [7:0] ak,
                      input logic [7:0] cnt, input logic sat);
    exp_t        e;
    logic [63:0] msk;
    int          n;
    n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      chk($sformatf("spurious_val%0d", id), 64'd1, 64'd0);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else if (id == 1) e = q1.pop_front();
    else e = q2.pop_front();
    msk = (64'd1 << cw(id)) - 64'd1;
    chk($sformatf("sum%0d", id), sum, 64'(e.sum) & msk);
    chk($sformatf("ai%0d", id), ai, e.ai);
    chk($sformatf("ak%0d", id), ak, e.ak);
    chk($sformatf("cnt%0d", id), cnt, e.cnt);
    chk($sformatf("sat%0d", id), sat, e.sat);
    chk($sformatf("lat%0d", id), cyc - e.cyc, LAT);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (v0) take(0, 64'(s0), ai0, ak0, c0, t0);
      if (v1) take(1, 64'(s1), ai1, ak1, c1, t1);
      if (v2) take(2, 64'(s2), ai2, ak2, c2, t2);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    row = '0; col = '0; val = 1'b0; last = 1'b0;
    ai_in = '0; ak_in = '0;
    m_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_val", v0, 0);
    chk("rst_sum", s0, 0);
    chk("rst_cnt", c0, 0);
    chk("rst_ai", ai0, 0);
    chk("rst_ak", ak0, 0);
    chk("rst_sat", t0, 0);
    chk("rst_sum_sgn", s1, 0);
    chk("rst_val_nar", v2, 0);
    rst_n = 1'b1;

    // Single beat dot product.
    drive(32'h04030201, 32'h08070605, 1, 1, 8'h11, 8'h22);
    idle(8);

    // Three all-ones beats with a bubble before the last.
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 8'h01, 8'h02);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 8'h03, 8'h04);
    idle(1);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 8'h05, 8'h06);
    idle(8);

    // Negative operands, back-to-back single-beat groups.
    drive(32'h80808080, 32'h7F7F7F7F, 1, 1, 8'hA0, 8'hB0);
    drive(32'h80808080, 32'h7F7F7F7F, 1, 1, 8'hA1, 8'hB1);
    idle(8);

    // Two max beats: overflows the 18-bit accumulator.
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 8'h30, 8'h31);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 8'h32, 8'h33);
    idle(8);

    // Reset halfway through a four-beat group.
    drive(32'h05050505, 32'h05050505, 1, 0, 8'h40, 8'h41);
    drive(32'h05050505, 32'h05050505, 1, 0, 8'h42, 8'h43);
    @(negedge clk);
    val = 1'b0;
    rst_n = 1'b0;
    m_busy = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    chk("mid_rst_val", v0, 0);
    chk("mid_rst_sum", s0, 0);
    chk("mid_rst_cnt", c0, 0);
    chk("mid_rst_ai", ai0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(32'h01010101, 32'h02020202, 1, 0, 8'h50, 8'h51);
    drive(32'h01010101, 32'h02020202, 1, 1, 8'h52, 8'h53);
    idle(8);

    // Tags change every beat; the last-beat tags must be emitted.
    for (int k = 0; k < 4; k++)
      drive(32'h01020304, 32'h04030201, 1, k == 3,
            8'(3 * k + 1), 8'(100 + k));
    idle(8);

    for (int g = 0; g < 25; g++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        drive($urandom, $urandom, 1, k == n - 1,
              8'($urandom), 8'($urandom));
      end
    end

    begin
      int w;
      w = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && w < 30) begin
        idle(1);
        w++;
      end
    end
    idle(4);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
